// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Multicycle PC control FSM with fetch/memory stalls, fetch timeout
//            and LUT-based relative branch targets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
   parameter int INIT_CYCLES = 2,
   parameter int LUT_DEPTH   = 16,
   parameter int CNT_W       = 16,
   parameter int FETCH_TMO   = 8
) (
   input  logic                         CLK,
   input  logic                         Init_n,
   input  logic                         Start,
   input  logic                         Instr_valid,
   input  logic                         Branch_req,
   input  logic                         Cond_true,
   input  logic [7:0]                   Target_idx,
   input  logic                         Halt_req,
   input  logic                         Mem_busy,
   input  logic                         Lut_we,
   input  logic [$clog2(LUT_DEPTH)-1:0] Lut_addr,
   input  logic [7:0]                   Lut_wdata,
   output logic                         Pc_init,
   output logic                         Pc_advance,
   output logic                         Branch_rel_en,
   output logic [7:0]                   Target,
   output logic                         Halt,
   output logic                         Fault,
   output logic [2:0]                   State,
   output logic [CNT_W-1:0]             Cycle_count
);

   localparam int AW = $clog2(LUT_DEPTH);
   localparam int IW = $clog2(INIT_CYCLES + 1);
   localparam int TW = $clog2(FETCH_TMO + 1);
   localparam logic [IW-1:0] c_init_last = IW'(INIT_CYCLES - 1);
   localparam logic [TW-1:0] c_tmo_last  = TW'(FETCH_TMO - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_FETCH  = 3'd2,
      S_EXEC   = 3'd3,
      S_BRANCH = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [IW-1:0]    r_init_cnt;
   logic [TW-1:0]    r_wait_cnt;
   logic [AW-1:0]    r_idx;
   logic             r_fault;
   logic [CNT_W-1:0] r_cycles;
   logic [7:0]       r_lut [LUT_DEPTH];
   logic             w_advance;
   logic             w_start;
   logic             w_timeout;
   logic             w_active;
   logic             w_lut_open;

   always_comb begin
      w_next    = r_state;
      w_advance = 1'b0;
      w_start   = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE, S_HALTED: begin
            if (Start) begin
               w_start = 1'b1;
               w_next  = S_INIT;
            end
         end
         S_INIT: begin
            if (r_init_cnt == c_init_last) w_next = S_FETCH;
         end
         S_FETCH: begin
            if (Instr_valid) begin
               w_next = S_EXEC;
            end else if (r_wait_cnt == c_tmo_last) begin
               w_timeout = 1'b1;
               w_next    = S_HALTED;
            end
         end
         S_EXEC: begin
            // A memory stall outranks every decoded request.
            if (!Mem_busy) begin
               if (Halt_req) begin
                  w_next = S_HALTED;
               end else if (Branch_req && Cond_true) begin
                  w_next = S_BRANCH;
               end else begin
                  w_advance = 1'b1;
                  w_next    = S_FETCH;
               end
            end
         end
         S_BRANCH: w_next = S_FETCH;
         default:  w_next = S_IDLE;
      endcase
   end

   assign w_active   = (r_state == S_INIT) || (r_state == S_FETCH) ||
                       (r_state == S_EXEC) || (r_state == S_BRANCH);
   assign w_lut_open = (r_state == S_IDLE) || (r_state == S_HALTED);

   always_ff @(posedge CLK or negedge Init_n) begin
      if (!Init_n) begin
         r_state    <= S_IDLE;
         r_init_cnt <= '0;
         r_wait_cnt <= '0;
         r_idx      <= '0;
         r_fault    <= 1'b0;
         r_cycles   <= '0;
      end else begin
         r_state    <= w_next;
         r_init_cnt <= (r_state == S_INIT) ? r_init_cnt + 1'b1 : '0;
         r_wait_cnt <= (r_state == S_FETCH && !Instr_valid) ? r_wait_cnt + 1'b1 : '0;
         if (r_state == S_EXEC) r_idx <= Target_idx[AW-1:0];
         if (w_start)        r_fault <= 1'b0;
         else if (w_timeout) r_fault <= 1'b1;
         if (w_start)                          r_cycles <= '0;
         else if (w_active && (r_cycles != '1)) r_cycles <= r_cycles + 1'b1;
      end
   end

   // LUT contents are deliberately left unreset.
   always_ff @(posedge CLK) begin
      if (Lut_we && w_lut_open) r_lut[Lut_addr] <= Lut_wdata;
   end

   assign Pc_init       = (r_state == S_INIT);
   assign Pc_advance    = w_advance;
   assign Branch_rel_en = (r_state == S_BRANCH);
   assign Target        = (r_state == S_BRANCH) ? r_lut[r_idx] : 8'h00;
   assign Halt          = (r_state == S_HALTED);
   assign Fault         = r_fault;
   assign State         = r_state;
   assign Cycle_count   = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Table-driven self-checking bench for pc_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

   logic        CLK = 1'b0;
   logic        Init_n;
   logic        Start, Instr_valid, Branch_req, Cond_true, Halt_req, Mem_busy, Lut_we;
   logic [7:0]  Target_idx, Lut_wdata;
   logic [3:0]  Lut_addr;
   logic        Pc_init, Pc_advance, Branch_rel_en, Halt, Fault;
   logic [7:0]  Target;
   logic [2:0]  State;
   logic [15:0] Cycle_count;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   pc_sequencer dut (
      .CLK(CLK), .Init_n(Init_n), .Start(Start), .Instr_valid(Instr_valid),
      .Branch_req(Branch_req), .Cond_true(Cond_true), .Target_idx(Target_idx),
      .Halt_req(Halt_req), .Mem_busy(Mem_busy), .Lut_we(Lut_we),
      .Lut_addr(Lut_addr), .Lut_wdata(Lut_wdata), .Pc_init(Pc_init),
      .Pc_advance(Pc_advance), .Branch_rel_en(Branch_rel_en), .Target(Target),
      .Halt(Halt), .Fault(Fault), .State(State), .Cycle_count(Cycle_count)
   );

   typedef struct {
      logic       start, iv, br, cd;
      logic [7:0] idx;
      logic       hr, mb, lwe;
      logic [2:0] st;
      logic       ini, adv, bre;
      logic [7:0] tgt;
      logic       hlt, flt;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs [39];

   function automatic vec_t mk(input logic s, iv, br, cd, input logic [7:0] idx,
                               input logic hr, mb, lwe, input logic [2:0] st,
                               input logic ini, adv, bre, input logic [7:0] tgt,
                               input logic hlt, flt, input logic [15:0] cnt);
      vec_t v;
      v.start = s; v.iv = iv; v.br = br; v.cd = cd; v.idx = idx;
      v.hr = hr; v.mb = mb; v.lwe = lwe; v.st = st; v.ini = ini;
      v.adv = adv; v.bre = bre; v.tgt = tgt; v.hlt = hlt; v.flt = flt; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] actual=%0h expected=%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int k, input vec_t v);
      chk("State", k, 32'(State), 32'(v.st));
      chk("Pc_init", k, 32'(Pc_init), 32'(v.ini));
      chk("Pc_advance", k, 32'(Pc_advance), 32'(v.adv));
      chk("Branch_rel_en", k, 32'(Branch_rel_en), 32'(v.bre));
      chk("Target", k, 32'(Target), 32'(v.tgt));
      chk("Halt", k, 32'(Halt), 32'(v.hlt));
      chk("Fault", k, 32'(Fault), 32'(v.flt));
      chk("Cycle_count", k, 32'(Cycle_count), 32'(v.cnt));
   endtask

   initial begin
      //            s  iv br cd idx    hr mb we  st ini adv bre tgt    hlt flt cnt
      vecs[0]  = mk(1, 0, 0, 0, 8'd0,  0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      vecs[1]  = mk(0, 0, 0, 0, 8'd0,  0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
      vecs[2]  = mk(0, 0, 0, 0, 8'd0,  0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 1);
      vecs[3]  = mk(0, 1, 0, 0, 8'd0,  0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0, 2);
      vecs[4]  = mk(0, 1, 0, 0, 8'd0,  0, 0, 0, 3, 0, 1, 0, 8'h00, 0, 0, 3);
      vecs[5]  = mk(0, 1, 0, 0, 8'd0,  0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0, 4);
      vecs[6]  = mk(0, 1, 0, 0, 8'd0,  0, 0, 0, 3, 0, 1, 0, 8'h00, 0, 0, 5);
      vecs[7]  = mk(0, 1, 0, 0, 8'd0,  0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0, 6);
      vecs[8]  = mk(0, 1, 1, 1, 8'd10, 0, 0, 0, 3, 0, 0, 0, 8'h00, 0, 0, 7);
      vecs[9]  = mk(0, 1, 0, 0, 8'd3,  0, 0, 0, 4, 0, 0, 1, 8'hF6, 0, 0, 8);
      vecs[10] = mk(0, 1, 0, 0, 8'd0,  0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0, 9);
      vecs[11] = mk(0, 1, 1, 0, 8'd10, 0, 0, 0, 3, 0, 1, 0, 8'h00, 0, 0, 10);
      vecs[12] = mk(0, 1, 0, 0, 8'd0,  0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0, 11);
      vecs[13] = mk(0, 1, 0, 0, 8'd0,  0, 1, 0, 3, 0, 0, 0, 8'h00, 0, 0, 12);
      vecs[14] = mk(0, 1, 0, 0, 8'd0,  0, 1, 0, 3, 0, 0, 0, 8'h00, 0, 0, 13);
      vecs[15] = mk(0, 1, 0, 0, 8'd0,  0, 1, 0, 3, 0, 0, 0, 8'h00, 0, 0, 14);
      vecs[16] = mk(0, 1, 0, 0, 8'd0,  0, 0, 0, 3, 0, 1, 0, 8'h00, 0, 0, 15);
      vecs[17] = mk(0, 1, 0, 0, 8'd0,  0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0, 16);
      vecs[18] = mk(0, 1, 0, 0, 8'd0,  1, 1, 0, 3, 0, 0, 0, 8'h00, 0, 0, 17);
      vecs[19] = mk(0, 1, 1, 1, 8'd10, 1, 0, 0, 3, 0, 0, 0, 8'h00, 0, 0, 18);
      vecs[20] = mk(0, 0, 0, 0, 8'd0,  0, 0, 0, 5, 0, 0, 0, 8'h00, 1, 0, 19);
      vecs[21] = mk(1, 0, 0, 0, 8'd0,  0, 0, 0, 5, 0, 0, 0, 8'h00, 1, 0, 19);
      vecs[22] = mk(0, 0, 0, 0, 8'd0,  0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
      vecs[23] = mk(0, 0, 0, 0, 8'd0,  0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 1);
      for (int i = 24; i < 32; i++)
         vecs[i] = mk(0, 0, 0, 0, 8'd0, 0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0, 16'(i - 22));
      vecs[32] = mk(0, 0, 0, 0, 8'd0,  0, 0, 0, 5, 0, 0, 0, 8'h00, 1, 1, 10);
      vecs[33] = mk(1, 0, 0, 0, 8'd0,  0, 0, 0, 5, 0, 0, 0, 8'h00, 1, 1, 10);
      vecs[34] = mk(0, 0, 0, 0, 8'd0,  0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
      vecs[35] = mk(0, 0, 0, 0, 8'd0,  0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 1);
      vecs[36] = mk(0, 1, 0, 0, 8'd0,  0, 0, 1, 2, 0, 0, 0, 8'h00, 0, 0, 2);
      vecs[37] = mk(0, 1, 1, 1, 8'd10, 0, 0, 0, 3, 0, 0, 0, 8'h00, 0, 0, 3);
      vecs[38] = mk(0, 0, 0, 0, 8'd0,  0, 0, 0, 4, 0, 0, 1, 8'hF6, 0, 0, 4);

      Init_n = 1'b0; Start = 0; Instr_valid = 0; Branch_req = 0; Cond_true = 0;
      Halt_req = 0; Mem_busy = 0; Lut_we = 0; Target_idx = 0; Lut_addr = 0;
      Lut_wdata = 0;
      repeat (2) @(negedge CLK);
      chk("reset_State", 0, 32'(State), 32'd0);
      chk("reset_outputs", 0,
          32'({Pc_init, Pc_advance, Branch_rel_en, Halt, Fault, Target}), 32'd0);
      chk("reset_Cycle_count", 0, 32'(Cycle_count), 32'd0);
      Init_n = 1'b1;

      // Program LUT[10]=F6 and LUT[3]=05 while idle.
      @(negedge CLK); Lut_we = 1; Lut_addr = 4'd10; Lut_wdata = 8'hF6;
      @(negedge CLK); Lut_addr = 4'd3; Lut_wdata = 8'h05;
      @(negedge CLK); Lut_we = 0; Lut_addr = 4'd10; Lut_wdata = 8'h11;

      for (int k = 0; k < 39; k++) begin
         if (k > 0) @(negedge CLK);
         Start = vecs[k].start; Instr_valid = vecs[k].iv; Branch_req = vecs[k].br;
         Cond_true = vecs[k].cd; Target_idx = vecs[k].idx; Halt_req = vecs[k].hr;
         Mem_busy = vecs[k].mb; Lut_we = vecs[k].lwe;
         #1;
         check_all(k, vecs[k]);
      end

      // Asynchronous reset in the middle of a BRANCH cycle.
      #1 Init_n = 1'b0;
      #1;
      chk("async_State", 39, 32'(State), 32'd0);
      chk("async_outputs", 39,
          32'({Pc_init, Pc_advance, Branch_rel_en, Halt, Fault, Target}), 32'd0);
      chk("async_Cycle_count", 39, 32'(Cycle_count), 32'd0);
      @(negedge CLK); Init_n = 1'b1;
      @(negedge CLK);
      chk("post_reset_State", 40, 32'(State), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
